mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Arbitrates the single-ported unified instruction/data memory between the fetch stage (IF requester) and the memory stage (D requester, loads/stores).
- Issues one memory access per cycle, tracks the owner of the one outstanding synchronous read, and routes returned data to the correct requester.
- Raises stall towards the pipeline control when fetch loses arbitration.
- Sits between the pipeline stages and the memory macro.

Parameters:
- ADDR_W, 12, word-address width driven to memory (byte address bits [ADDR_W+1:2]).
- STARVE_MAX, 3, consecutive lost IF arbitration cycles before IF is forced to win once.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request, held until granted
- if_addr  in  32  fetch byte address, word aligned
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  instruction word valid on if_rdata this cycle
- if_rdata  out  32  instruction word
- stall_if  out  1  if_req & ~if_gnt
- d_req  in  1  data request, held until granted
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word (funct3[1:0])
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, LSB-aligned
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  load word valid on d_rdata this cycle
- d_rdata  out  32  raw aligned memory word (extension done downstream)
- d_err  out  1  one-cycle pulse: misaligned access rejected
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write enable
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data, lane-shifted
- mem_rdata  in  32  read data, valid one cycle after a read with mem_en=1

Behaviour:
- Arbitration (combinational, every cycle):
  - D wins over IF by default.
  - IF wins when starve_cnt == STARVE_MAX and both request.
  - A misaligned D request never wins and never touches memory.
- Misaligned D request:
  - half with addr[0]=1, or word with addr[1:0]!=0, or d_size=11.
  - Response: d_gnt=1, d_err=1 for that cycle, mem_en=0; IF may be granted in the same cycle.
- Byte lanes:
  - be = 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, 1111 for word.
  - mem_wdata = d_wdata << (8*addr[1:0]).
  - mem_addr = addr[ADDR_W+1:2].
- Owner register:
  - Reset value NONE.
  - Next value: IF if IF read granted, D if D load granted, NONE otherwise (stores and idle cycles).
  - Owner==IF: if_rvalid=1, if_rdata=mem_rdata.
  - Owner==D: d_rvalid=1, d_rdata=mem_rdata.
  - Otherwise both rvalid=0 and both rdata=0.
- Pipelining: a new grant in cycle N coexists with the return of cycle N-1's read; no bubble between back-to-back reads.
- Starvation counter (sat. at STARVE_MAX, 2 bits default):
  - Increments when if_req & ~if_gnt.
  - Clears on if_gnt or ~if_req.
- Stores: no rvalid; completion is the granted cycle.
- Idle: mem_en=0, mem_we=0, mem_be=0000, mem_addr/mem_wdata hold 0.
- Reset (any time, asynchronous):
  - owner=NONE, starve_cnt=0.
  - All registered outputs (if_rvalid, d_rvalid, rdata) go to 0 immediately.
  - An in-flight read's data is discarded.
  - Combinational outputs follow the inputs with owner=NONE.
- Latency: grant 0 cycles; read data 1 cycle after grant.

Decomposition:
- Shared package/defines:
  - owner encoding OWN_NONE=2'd0, OWN_IF=2'd1, OWN_D=2'd2
  - size codes SZ_B/SZ_H/SZ_W
- One natural sub-module: mem_lane_align, combinational. It produces mem_be, the shifted mem_wdata and the misalign flag from d_size/d_addr/d_wdata.
- The arbiter, owner register and starvation counter stay in the top.

Test Plan:
- Reset then IF only, if_addr=0x10, mem word 0x00500093 → if_gnt=1 in cycle 0, mem_addr=4, mem_en=1; next cycle if_rvalid=1, if_rdata=0x00500093, d_rvalid=0.
- Both request with d_we=0, d_addr=0x20, STARVE_MAX=3 → d_gnt=1, stall_if=1; next cycle d_rvalid=1; continuous D load requests: IF granted on 4th conflict cycle, starve_cnt cleared.
- Store byte d_addr=0x23, d_wdata=0xAB → mem_we=1, mem_be=1000, mem_wdata=0xAB000000, mem_addr=8; no d_rvalid next cycle.
- Store half d_addr=0x21 → d_err=1, d_gnt=1, mem_en=0, owner stays NONE; simultaneous if_req is granted in the same cycle.
- Back-to-back IF read (cycle 0) then D load (cycle 1) → cycle 1 if_rvalid=1; cycle 2 d_rvalid=1; no idle cycle between them.
- IF read granted, rst asserted mid-cycle before data returns → if_rvalid=0 immediately; after release owner=NONE and no spurious rvalid.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: read-owner
// encoding, access size codes and the alignment rule.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    // Size code 11 has no legal meaning, so it is rejected like a misalignment.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane steering for the data port: byte enables, lane-shifted store
// data and the misaligned-access flag.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic        misalign
);

    always_comb begin
        be = 4'b0000;
        case (size_e'(size))
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = 4'b0011 << off;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        wdata_sh = wdata << {off, 3'b000};
        misalign = is_misaligned(size_e'(size), off);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-ported unified memory shared by fetch and the
// memory stage; tracks who owns the one outstanding read.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              stall_if,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    owner_e           owner;
    owner_e           owner_nxt;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;
    logic             lane_misalign;
    logic             d_ok;
    logic             if_forced;
    logic             d_mem;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2]};

    mem_lane_align u_lane_align (
        .size     (d_size),
        .off      (d_addr[1:0]),
        .wdata    (d_wdata),
        .be       (lane_be),
        .wdata_sh (lane_wdata),
        .misalign (lane_misalign)
    );

    // D normally owns the port; a starved fetch steals exactly one conflict cycle.
    assign d_ok      = d_req & ~lane_misalign;
    assign if_forced = if_req & d_ok & (starve_cnt == CNT_W'(STARVE_MAX));
    assign d_mem     = d_ok & ~if_forced;
    assign if_gnt    = if_req & ~d_mem;
    assign d_gnt     = d_req & (lane_misalign | d_mem);
    assign d_err     = d_req & lane_misalign;
    assign stall_if  = if_req & ~if_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_nxt = OWN_NONE;
        if (d_mem) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = lane_be;
            mem_addr  = d_addr[ADDR_W+1:2];
            mem_wdata = d_we ? lane_wdata : 32'd0;
            owner_nxt = d_we ? OWN_NONE : OWN_D;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_be    = 4'b1111;
            mem_addr  = if_addr[ADDR_W+1:2];
            owner_nxt = OWN_IF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            owner <= owner_nxt;
            if (stall_if) begin
                if (starve_cnt != CNT_W'(STARVE_MAX))
                    starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // Read data lands one cycle after the grant and goes only to the recorded owner.
    assign if_rvalid = (owner == OWN_IF);
    assign d_rvalid  = (owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
    assign d_rdata   = d_rvalid ? mem_rdata : 32'd0;

endmodule
